// File: rtl/conv_index_unit.sv
// Index and address datapath for the 3x3 convolution engine: it holds the image
// dimensions, the column/row counters and the SRAM addresses, and returns status flags.
module conv_index_unit #(
  parameter int          ADDR_W   = 12,
  parameter int          DIM_W    = 8,
  parameter logic [15:0] END_MARK = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [15:0]       sram_dut_read_data,
  input  logic              init,
  input  logic              str_input_nrows,
  input  logic              str_input_ncols,
  input  logic              incr_col_enable,
  input  logic              rst_col_counter,
  input  logic              incr_row_enable,
  input  logic              rst_row_counter,
  input  logic              incr_raddr_enable,
  input  logic              incr_waddr_enable,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [15:0]       input_num_rows,
  output logic [15:0]       input_num_cols,
  output logic [DIM_W-1:0]  cidx,
  output logic [DIM_W-1:0]  ridx,
  output logic              last_col_next,
  output logic              last_row_flag,
  output logic              end_condition_met,
  output logic              dim_error
);

  localparam logic [16:0] DIM_MAX = 17'd1 << DIM_W;

  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       nrows_q, nrows_d;
  logic [15:0]       ncols_q, ncols_d;
  logic [DIM_W-1:0]  cidx_q, cidx_d;
  logic [DIM_W-1:0]  ridx_q, ridx_d;
  logic              dim_error_q, dim_error_d;

  // A header is malformed if either dimension is too small for a 3x3 window
  // or too large for the counters to index.
  function automatic logic hdr_bad(input logic [15:0] rows, input logic [15:0] cols);
    logic [16:0] r17, c17;
    r17 = {1'b0, rows};
    c17 = {1'b0, cols};
    return (r17 < 17'd3) || (c17 < 17'd3) || (r17 > DIM_MAX) || (c17 > DIM_MAX);
  endfunction

  always_comb begin
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    nrows_d     = nrows_q;
    ncols_d     = ncols_q;
    cidx_d      = cidx_q;
    ridx_d      = ridx_q;
    dim_error_d = dim_error_q;

    if (str_input_nrows) nrows_d = sram_dut_read_data;
    if (str_input_ncols) ncols_d = sram_dut_read_data;

    if (init) begin
      raddr_d     = '0;
      waddr_d     = '0;
      cidx_d      = '0;
      ridx_d      = '0;
      dim_error_d = 1'b0;
    end else begin
      if (rst_col_counter)      cidx_d = '0;
      else if (incr_col_enable) cidx_d = cidx_q + DIM_W'(1);
      if (rst_row_counter)      ridx_d = '0;
      else if (incr_row_enable) ridx_d = ridx_q + DIM_W'(1);
      if (incr_raddr_enable)    raddr_d = raddr_q + ADDR_W'(1);
      if (incr_waddr_enable)    waddr_d = waddr_q + ADDR_W'(1);
      // The check pairs the incoming column word with the rows already latched.
      if (str_input_ncols && !end_condition_met && hdr_bad(nrows_q, sram_dut_read_data))
        dim_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      raddr_q     <= '0;
      waddr_q     <= '0;
      nrows_q     <= '0;
      ncols_q     <= '0;
      cidx_q      <= '0;
      ridx_q      <= '0;
      dim_error_q <= 1'b0;
    end else begin
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      nrows_q     <= nrows_d;
      ncols_q     <= ncols_d;
      cidx_q      <= cidx_d;
      ridx_q      <= ridx_d;
      dim_error_q <= dim_error_d;
    end
  end

  // Flags compare in 17 bits so a counter wrap can never alias onto a dimension.
  assign last_col_next     = ((17'(cidx_q) + 17'd1) == {1'b0, ncols_q}) && (ncols_q != 16'd0);
  assign last_row_flag     = ((17'(ridx_q) + 17'd3) == {1'b0, nrows_q}) && (nrows_q >= 16'd3);
  assign end_condition_met = (nrows_q == END_MARK);

  assign dut_sram_read_address  = raddr_q;
  assign dut_sram_write_address = waddr_q;
  assign input_num_rows         = nrows_q;
  assign input_num_cols         = ncols_q;
  assign cidx                   = cidx_q;
  assign ridx                   = ridx_q;
  assign dim_error              = dim_error_q;

endmodule

// File: tb/tb_conv_index_unit.sv
// Scoreboard bench for conv_index_unit: the driver predicts each cycle's state with an
// integer model and queues it; the monitor compares after every rising edge.
module tb_conv_index_unit;

  localparam int ADDR_W = 12;
  localparam int DIM_W  = 8;
  localparam int END_M  = 255;

  logic              clk = 1'b0;
  logic              reset_b;
  logic [15:0]       rdata;
  logic              init, snr, snc, ic, rc, ir, rr, ira, iwa;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [15:0]       nrows, ncols;
  logic [DIM_W-1:0]  cidx, ridx;
  logic              lcn, lrf, ecm, derr;

  conv_index_unit #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .END_MARK(16'h00FF)) dut (
    .clk(clk), .reset_b(reset_b), .sram_dut_read_data(rdata), .init(init),
    .str_input_nrows(snr), .str_input_ncols(snc),
    .incr_col_enable(ic), .rst_col_counter(rc),
    .incr_row_enable(ir), .rst_row_counter(rr),
    .incr_raddr_enable(ira), .incr_waddr_enable(iwa),
    .dut_sram_read_address(raddr), .dut_sram_write_address(waddr),
    .input_num_rows(nrows), .input_num_cols(ncols), .cidx(cidx), .ridx(ridx),
    .last_col_next(lcn), .last_row_flag(lrf), .end_condition_met(ecm), .dim_error(derr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ra, wa, nr, nc, c, r;
    bit lcn, lrf, ecm, de;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_ra, m_wa, m_nr, m_nc, m_c, m_r;
  bit   m_de;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ra = 0; m_wa = 0; m_nr = 0; m_nc = 0; m_c = 0; m_r = 0; m_de = 0;
  endtask

  task automatic drive_idle();
    init = 0; snr = 0; snc = 0; ic = 0; rc = 0; ir = 0; rr = 0; ira = 0; iwa = 0;
    rdata = 16'h0;
  endtask

  // One command cycle: drive strobes, advance the reference model, queue the expectation.
  task automatic step(input bit i_init, input bit i_snr, input bit i_snc, input bit i_ic,
                      input bit i_rc, input bit i_ir, input bit i_rr, input bit i_ira,
                      input bit i_iwa, input int data);
    exp_t e;
    bit   bad_hdr;
    @(negedge clk);
    init = i_init; snr = i_snr; snc = i_snc; ic = i_ic; rc = i_rc;
    ir = i_ir; rr = i_rr; ira = i_ira; iwa = i_iwa; rdata = 16'(data);
    bad_hdr = i_snc && (m_nr != END_M) &&
              (m_nr < 3 || data < 3 || m_nr > (1 << DIM_W) || data > (1 << DIM_W));
    if (i_init) begin
      m_ra = 0; m_wa = 0; m_c = 0; m_r = 0; m_de = 0;
    end else begin
      if (i_rc) m_c = 0; else if (i_ic) m_c = (m_c + 1) % (1 << DIM_W);
      if (i_rr) m_r = 0; else if (i_ir) m_r = (m_r + 1) % (1 << DIM_W);
      if (i_ira) m_ra = (m_ra + 1) % (1 << ADDR_W);
      if (i_iwa) m_wa = (m_wa + 1) % (1 << ADDR_W);
      if (bad_hdr) m_de = 1;
    end
    if (i_snr) m_nr = data;
    if (i_snc) m_nc = data;
    e.ra = m_ra; e.wa = m_wa; e.nr = m_nr; e.nc = m_nc; e.c = m_c; e.r = m_r; e.de = m_de;
    e.lcn = (m_nc != 0) && (m_c + 1 == m_nc);
    e.lrf = (m_nr >= 3) && (m_r + 3 == m_nr);
    e.ecm = (m_nr == END_M);
    q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_raddr"}, int'(raddr), 0);
    chk({tag, "_waddr"}, int'(waddr), 0);
    chk({tag, "_nrows"}, int'(nrows), 0);
    chk({tag, "_ncols"}, int'(ncols), 0);
    chk({tag, "_cidx"}, int'(cidx), 0);
    chk({tag, "_ridx"}, int'(ridx), 0);
    chk({tag, "_flags"}, int'({lcn, lrf, ecm, derr}), 0);
  endtask

  // Monitor: the unit presents a new state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("raddr", int'(raddr), e.ra);
        chk("waddr", int'(waddr), e.wa);
        chk("nrows", int'(nrows), e.nr);
        chk("ncols", int'(ncols), e.nc);
        chk("cidx", int'(cidx), e.c);
        chk("ridx", int'(ridx), e.r);
        chk("last_col_next", int'(lcn), int'(e.lcn));
        chk("last_row_flag", int'(lrf), int'(e.lrf));
        chk("end_condition_met", int'(ecm), int'(e.ecm));
        chk("dim_error", int'(derr), int'(e.de));
      end
    end
  end

  function automatic int pick_data();
    case ($urandom_range(0, 7))
      0, 1:    return int'($urandom_range(0, 10));
      2:       return END_M;
      3:       return int'($urandom_range(254, 258));
      4:       return int'($urandom_range(3, 256));
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    drive_idle();
    model_reset();
    reset_b = 1'b0;
    #3;
    chk_all_zero("por");
    @(negedge clk);
    reset_b = 1'b1;

    // Header 5x4, column sweep, row end.
    step(0,1,0,0,0,0,0,0,0, 5);
    step(0,0,1,0,0,0,0,0,0, 4);
    repeat (4) step(0,0,0,1,0,0,0,0,0, 0);
    step(0,0,0,1,1,0,0,0,0, 0);
    repeat (2) step(0,0,0,0,0,1,0,0,0, 0);
    step(0,0,0,0,0,0,1,0,0, 0);

    // End marker suppresses the header check; then a 2x7 header errors until init.
    step(0,1,0,0,0,0,0,0,0, 16'h00FF);
    step(0,0,1,0,0,0,0,0,0, 2);
    step(0,0,1,0,0,0,0,0,0, 0);
    step(0,0,1,0,0,0,0,0,0, 1000);
    step(0,1,0,0,0,0,0,0,0, 2);
    step(0,0,1,0,0,0,0,0,0, 7);
    repeat (3) step(0,0,0,1,0,0,0,1,0, 0);
    step(1,0,0,0,0,0,0,0,0, 0);

    // Write address pulses, then init wins over a concurrent increment.
    repeat (3) step(0,0,0,0,0,0,0,0,1, 0);
    step(1,0,0,0,0,0,0,0,1, 0);

    // Mid-sweep asynchronous reset at cidx=5, raddr=0x2A.
    step(0,1,0,0,0,0,0,0,0, 9);
    step(0,0,1,0,0,0,0,0,0, 9);
    for (int i = 0; i < 42; i++) step(0,0,0,(i < 5),0,0,0,1,0, 0);
    @(negedge clk);
    drive_idle();
    #2 reset_b = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    #1 reset_b = 1'b1;

    // Read address wrap.
    repeat (4095) step(0,0,0,0,0,0,0,1,0, 0);
    @(posedge clk);
    #2 chk("raddr_top", int'(raddr), 12'hFFF);
    step(0,0,0,0,0,0,0,1,0, 0);
    @(posedge clk);
    #2 chk("raddr_wrap", int'(raddr), 0);

    // Randomized commands.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 1) == 0), pick_data());
    end

    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
